serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Upstream stage of the "101" pattern detector. It accepts parallel words through a valid/ready handshake and serializes them one bit per clock onto the `dataout` line, which drives the detector's `datain`. A one-word holding buffer lets the next word be accepted while the current one shifts, so back-to-back words stream with no idle gap. When no word is available it drives a fixed idle level, so the detector always sees a defined bit.

## Interface
- `WIDTH`, 8: word width in bits; must be at least 2.
- `MSB_FIRST`, 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.
- `IDLE_BIT`, 0: level driven on `dataout` when no word is shifting.

- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous active-low reset
- `din`  in  WIDTH  parallel word
- `din_valid`  in  1  `din` holds a word
- `din_ready`  out  1  block can accept a word this cycle
- `dataout`  out  1  serial bit; connects to the detector's `datain`
- `dataout_valid`  out  1  `dataout` carries a word bit, not idle fill
- `busy`  out  1  shifter active or holding buffer full
- `word_done`  out  1  high during the cycle the last bit of a word is on `dataout`

## Operation
- Storage:
  - holding register `hold` with flag `hold_full`;
  - shift register `shreg` with flag `shift_act`;
  - bit counter `cnt`, 0..WIDTH-1, `$clog2(WIDTH)` bits.
- `din_ready = !hold_full`. It is a register-derived signal with no combinational path from `din_valid`.
- Accept: on an edge where `din_valid && din_ready`, `din` is captured into `hold` and `hold_full` is set.
- States:
  - IDLE: `shift_act` = 0.
  - SHIFT: `shift_act` = 1.
- IDLE -> SHIFT: on an edge where `hold_full` = 1. The edge does all of the following:
  - `hold` is copied to `shreg`;
  - `cnt` is set to 0;
  - `hold_full` is cleared, unless a new accept happens on the same edge, in which case `hold` takes the new word and `hold_full` stays 1.
- SHIFT with `cnt < WIDTH-1`: each edge advances `shreg` by one bit toward the output end and increments `cnt`.
- SHIFT with `cnt == WIDTH-1` (last bit):
  - if `hold_full`, the edge reloads `shreg` from `hold`, sets `cnt` to 0 and stays in SHIFT (seamless reload);
  - otherwise the edge goes to IDLE.
- `dataout` selection:
  - in SHIFT: `shreg[WIDTH-1]` when `MSB_FIRST`=1, else `shreg[0]`;
  - in IDLE: `IDLE_BIT`.
- Status outputs:
  - `dataout_valid = shift_act`;
  - `busy = shift_act | hold_full`;
  - `word_done = shift_act && cnt == WIDTH-1`.
- Simultaneous accept and hold drain on the same edge: both take effect. The old `hold` goes to `shreg`, the new `din` goes to `hold`, and no word is lost or duplicated.
- `din_valid` while `din_ready` = 0: ignored. The upstream source must hold the word.
- Reset (asynchronous, at any time including mid-word):
  - `hold_full`, `shift_act` and `cnt` are cleared;
  - any partial word is discarded and never resumed.

## Timing
- Reset values:
  - `dataout` = `IDLE_BIT`;
  - `dataout_valid` = 0;
  - `din_ready` = 1;
  - `busy` = 0;
  - `word_done` = 0.
- Latency with the block idle:
  - word accepted at edge N;
  - first bit on `dataout` after edge N+1;
  - last bit after edge N+WIDTH, with `word_done` high for that cycle;
  - after edge N+WIDTH+1, `dataout` returns to `IDLE_BIT` if nothing is queued.
- Sustained throughput: one word per WIDTH cycles, with `dataout_valid` continuously high.
- `din_ready` behaviour:
  - it goes low for at least one cycle after each accept;
  - during streaming it reasserts on the edge where `hold` moves to `shreg`.
- All outputs change only on rising `clk`, except the asynchronous reset.

## Test plan
- Reset: assert `rstn`=0 mid-stream, then release.
  - -> all outputs at their reset values while reset is asserted;
  - -> the next word starts with `cnt`=0.
- Single word, `WIDTH`=8, `MSB_FIRST`=1: `din`=8'b1010_0101 accepted at edge N.
  - -> `dataout` = 1,0,1,0,0,1,0,1 on cycles N+1..N+8;
  - -> `word_done` high only in cycle N+8;
  - -> idle 0 afterwards.
- Back-to-back: `din_valid` held high with words 8'hA5 then 8'h3C.
  - -> 16 contiguous valid bits with no gap;
  - -> `din_ready` low while `hold_full`.
- `MSB_FIRST`=0: `din`=8'h01.
  - -> `dataout` = 1 in the first bit cycle, then seven 0s.
- End-to-end with the detector: stream 8'b1010_1010, `MSB_FIRST`=1.
  - -> the detector sees 1,0,1,0,1,0,1,0;
  - -> with non-overlapping detection, exactly two `pattern_detected` pulses.
- Hold drain and accept on the same edge: present word B exactly on the edge where word A moves from `hold` to `shreg`.
  - -> both words are emitted in order A then B;
  - -> no drop, no duplicate.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for the "101" pattern detector.
// Words arrive over a valid/ready handshake into a one-word holding buffer and are
// shifted out one bit per clock. The buffer lets the next word queue up while the
// current one shifts, so consecutive words stream with no idle gap. When nothing is
// shifting the serial line sits at IDLE_BIT so the detector always sees a defined level.

module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dataout,
    output logic             dataout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic din_ready_q, din_ready_d;
    logic dataout_q, dataout_d;
    logic dataout_valid_q, dataout_valid_d;
    logic busy_q, busy_d;
    logic word_done_q, word_done_d;

    logic accept;
    logic last_bit;
    logic load;

    // Next-state logic: handshake capture, hold->shift transfer, shifting, and the
    // registered status outputs derived from the state that the edge will produce.
    always_comb begin
        accept   = din_valid && din_ready_q;
        last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        load     = hold_full_q && ((state_q == ST_IDLE) || last_bit);

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        hold_d      = accept ? din : hold_q;
        hold_full_d = accept | (hold_full_q & ~load);

        if (load) begin
            shreg_d = hold_q;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end else if (last_bit) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_ONE;
        end

        din_ready_d     = ~hold_full_d;
        dataout_valid_d = (state_d == ST_SHIFT);
        busy_d          = (state_d == ST_SHIFT) | hold_full_d;
        word_done_d     = (state_d == ST_SHIFT) && (cnt_d == CNT_LAST);
        if (state_d == ST_SHIFT) begin
            dataout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            dataout_d = IDLE_BIT;
        end
    end

    // State and output registers; reset drops any partial word and the buffered word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            shreg_q         <= '0;
            cnt_q           <= '0;
            din_ready_q     <= 1'b1;
            dataout_q       <= IDLE_BIT;
            dataout_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            word_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            shreg_q         <= shreg_d;
            cnt_q           <= cnt_d;
            din_ready_q     <= din_ready_d;
            dataout_q       <= dataout_d;
            dataout_valid_q <= dataout_valid_d;
            busy_q          <= busy_d;
            word_done_q     <= word_done_d;
        end
    end

    assign din_ready     = din_ready_q;
    assign dataout       = dataout_q;
    assign dataout_valid = dataout_valid_q;
    assign busy          = busy_q;
    assign word_done     = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: drives two feeders (MSB-first and LSB-first) with the same
// handshake traffic and compares every output each cycle against a schedule-based
// reference: each accepted word is booked into a timeline starting at the later of
// "one cycle after accept" and "one cycle after the previous word ends".

module tb_serial_bit_feeder;

    localparam int W    = 8;
    localparam int MAXC = 2048;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] din;
    logic         din_valid;

    logic ready_m, dout_m, dv_m, busy_m, done_m;
    logic ready_l, dout_l, dv_l, busy_l, done_l;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
        .din_ready(ready_m), .dataout(dout_m), .dataout_valid(dv_m),
        .busy(busy_m), .word_done(done_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
        .din_ready(ready_l), .dataout(dout_l), .dataout_valid(dv_l),
        .busy(busy_l), .word_done(done_l)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    bit exp_valid [0:MAXC-1];
    bit exp_done  [0:MAXC-1];
    bit exp_bit_m [0:MAXC-1];
    bit exp_bit_l [0:MAXC-1];
    int cyc;
    int busy_until;
    int pend_start;
    int errors;
    int checks;
    int run_len;
    int last_run;
    bit obs_m[$];
    bit obs_l[$];

    function automatic bit modelHoldFull(input int c);
        return (pend_start >= 0) && (c < pend_start);
    endfunction

    function automatic int count101(input bit q[$]);
        int n = 0;
        int i = 0;
        while (i + 2 < q.size()) begin
            if (q[i] == 1'b1 && q[i+1] == 1'b0 && q[i+2] == 1'b1) begin
                n++;
                i += 3;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    task automatic clearModel();
        for (int c = cyc; c < MAXC; c++) begin
            exp_valid[c] = 1'b0;
            exp_done[c]  = 1'b0;
            exp_bit_m[c] = 1'b0;
            exp_bit_l[c] = 1'b0;
        end
        pend_start = -1;
        busy_until = cyc;
    endtask

    task automatic scheduleWord(input logic [W-1:0] d);
        int start;
        start = (cyc + 1 > busy_until + 1) ? cyc + 1 : busy_until + 1;
        for (int k = 0; k < W; k++) begin
            if (start + k < MAXC) begin
                exp_valid[start+k] = 1'b1;
                exp_done[start+k]  = (k == W - 1);
                exp_bit_m[start+k] = d[W-1-k];
                exp_bit_l[start+k] = d[k];
            end
        end
        busy_until = start + W - 1;
        pend_start = start;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, observed, expected);
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        bit ev;
        bit hf;
        ev = exp_valid[cyc];
        hf = modelHoldFull(cyc);
        checkOutput("valid_msb", dv_m, ev);
        checkOutput("valid_lsb", dv_l, ev);
        checkOutput("dout_msb", dout_m, ev ? exp_bit_m[cyc] : 1'b0);
        checkOutput("dout_lsb", dout_l, ev ? exp_bit_l[cyc] : 1'b0);
        checkOutput("ready_msb", ready_m, ~hf);
        checkOutput("ready_lsb", ready_l, ~hf);
        checkOutput("busy_msb", busy_m, ev | hf);
        checkOutput("busy_lsb", busy_l, ev | hf);
        checkOutput("done_msb", done_m, exp_done[cyc]);
        checkOutput("done_lsb", done_l, exp_done[cyc]);
    endtask

    // One clock cycle: drive inputs while clk is low, book an accept, check after the edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, output bit acc);
        din_valid = v;
        din       = d;
        acc       = v && rstn && !modelHoldFull(cyc);
        @(posedge clk);
        cyc++;
        if (acc) scheduleWord(d);
        #1;
        checkAll();
        if (dv_m === 1'b1) obs_m.push_back(dout_m);
        if (dv_l === 1'b1) obs_l.push_back(dout_l);
        if (dv_m === 1'b1) begin
            run_len++;
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
        @(negedge clk);
    endtask

    task automatic sendWord(input logic [W-1:0] d);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 40) begin
            applyStimulus(1'b1, d, acc);
            tries++;
        end
        if (!acc) checkOutput("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, acc);
    endtask

    task automatic doReset(input int n);
        rstn = 1'b0;
        #1;
        clearModel();
        checkAll();
        idleCycles(n);
        rstn = 1'b1;
    endtask

    initial begin
        bit acc;
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        run_len   = 0;
        last_run  = 0;
        din       = '0;
        din_valid = 1'b0;
        rstn      = 1'b0;
        clearModel();

        // Power-on reset.
        @(negedge clk);
        doReset(2);

        // Single word A5, MSB-first stream and word_done timing.
        obs_m.delete();
        sendWord(8'hA5);
        idleCycles(12);
        checkInt("single_len", obs_m.size(), 8);
        wa = 8'hA5;
        for (int k = 0; k < W && k < obs_m.size(); k++) checkOutput("single_bit", obs_m[k], wa[W-1-k]);

        // Back-to-back with valid held high.
        run_len = 0;
        last_run = 0;
        sendWord(8'hA5);
        sendWord(8'h3C);
        idleCycles(20);
        checkInt("b2b_run", last_run, 16);

        // LSB-first word 01.
        obs_l.delete();
        sendWord(8'h01);
        idleCycles(10);
        checkInt("lsb_len", obs_l.size(), 8);
        for (int k = 0; k < W && k < obs_l.size(); k++) checkOutput("lsb_bit", obs_l[k], (k == 0));

        // AA through a non-overlapping 101 detector.
        obs_m.delete();
        sendWord(8'hAA);
        idleCycles(10);
        checkInt("detect_101", count101(obs_m), 2);

        // Word B presented on the edge where A leaves the holding buffer.
        obs_m.delete();
        wa = 8'h5E;
        wb = 8'hC1;
        applyStimulus(1'b1, wa, acc);
        checkOutput("drain_accA", acc, 1'b1);
        sendWord(wb);
        idleCycles(20);
        checkInt("drain_len", obs_m.size(), 16);
        for (int k = 0; k < W && k + W < obs_m.size(); k++) begin
            checkOutput("drain_A", obs_m[k], wa[W-1-k]);
            checkOutput("drain_B", obs_m[k+W], wb[W-1-k]);
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), W'($urandom), acc);
        end
        idleCycles(20);

        // Reset mid-stream, then a fresh word.
        sendWord(8'hC3);
        sendWord(8'h81);
        idleCycles(3);
        doReset(2);
        sendWord(8'h96);
        idleCycles(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
